mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 60 ++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between instruction fetch and the MEM stage
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    owner_t     rsp_owner_q, rsp_owner_d;
    logic       if_pri;

    // grant selection, RAM port mux and next-state for starvation counter and response tag
    always_comb begin
        if_pri      = if_req && (starve_q >= LIMIT);
        if_gnt      = resetn && if_req && (if_pri || !mem_req);
        mem_gnt     = resetn && mem_req && !if_gnt;
        ram_en      = if_gnt || mem_gnt;
        ram_wen     = mem_gnt ? mem_wen : 4'b0000;
        ram_addr    = if_gnt ? if_addr : (mem_gnt ? mem_addr : 32'd0);
        ram_wdata   = mem_gnt ? mem_wdata : 32'd0;
        starve_d    = (if_req && !if_gnt) ? ((starve_q == 4'hF) ? starve_q : starve_q + 4'd1) : 4'd0;
        rsp_owner_d = if_gnt ? OWN_IF : ((mem_gnt && mem_wen == 4'b0000) ? OWN_MEM : OWN_NONE);
        if_rvalid   = (rsp_owner_q == OWN_IF);
        mem_rvalid  = (rsp_owner_q == OWN_MEM);
        if_rdata    = ram_rdata;
        mem_rdata   = ram_rdata;
    end

    // state registers; reset drops any response still in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q    <= 4'd0;
            rsp_owner_q <= OWN_NONE;
        end else begin
            starve_q    <= starve_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard-based bench for mem_port_arbiter with a behavioural synchronous RAM
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, mem_req;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rdata = 32'd0;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] ram [0:255];
    int          tests = 0;
    int          fails = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // behavioural synchronous RAM: one-cycle read latency, byte-lane writes
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen == 4'b0000) ram_rdata <= ram[ram_addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (ram_wen[i]) ram[ram_addr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    // response monitor: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (resetn) begin
            if (if_rvalid && mem_rvalid) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL both_rvalid: got if_rvalid=1 mem_rvalid=1, required at most one");
            end
            if (if_rvalid || mem_rvalid) begin
                tests = tests + 1;
                if (sb.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_rvalid: got if=%b mem=%b, required no response", if_rvalid, mem_rvalid);
                end else begin
                    e = sb.pop_front();
                    if (mem_rvalid !== e.is_mem || (mem_rvalid ? mem_rdata : if_rdata) !== e.data) begin
                        fails = fails + 1;
                        $display("FAIL response: got mem=%b data=%h, required mem=%b data=%h",
                                 mem_rvalid, mem_rvalid ? mem_rdata : if_rdata, e.is_mem, e.data);
                    end
                end
            end
        end
    end

    task automatic push(input logic is_mem, input logic [31:0] data);
        exp_t x;
        x.is_mem = is_mem;
        x.data   = data;
        sb.push_back(x);
    endtask

    task automatic idle();
        if_req    = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 4'b0000;
        if_addr   = 32'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        #1;
        if_req  = 1'b1;
        mem_req = 1'b1;
        #2;
        tests = tests + 1;
        if ({if_gnt, mem_gnt, ram_en, ram_wen} !== 7'd0) begin
            fails = fails + 1;
            $display("FAIL reset_grants: got gnt/en/wen=%b, required 0000000", {if_gnt, mem_gnt, ram_en, ram_wen});
        end
        tests = tests + 1;
        if ({if_rvalid, mem_rvalid} !== 2'b00) begin
            fails = fails + 1;
            $display("FAIL reset_rvalid: got %b, required 00", {if_rvalid, mem_rvalid});
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sole_fetch();
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({if_gnt, mem_gnt, ram_en, ram_wen} !== 7'b1010000 || ram_addr !== 32'h100) begin
            fails = fails + 1;
            $display("FAIL sole_fetch_grant: got gnt/en/wen=%b addr=%h, required 1010000 addr=00000100",
                     {if_gnt, mem_gnt, ram_en, ram_wen}, ram_addr);
        end
        push(1'b0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        #1;
        tests = tests + 1;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            fails = fails + 1;
            $display("FAIL sole_fetch_data: got rvalid=%b data=%h, required 1 deadbeef", if_rvalid, if_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        if_req   = 1'b1;
        if_addr  = 32'h104;
        mem_req  = 1'b1;
        mem_addr = 32'h200;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({if_gnt, mem_gnt} !== 2'b01 || ram_addr !== 32'h200) begin
            fails = fails + 1;
            $display("FAIL simul_mem_first: got gnt=%b addr=%h, required 01 addr=00000200", {if_gnt, mem_gnt}, ram_addr);
        end
        push(1'b1, 32'h11112222);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({if_gnt, mem_gnt} !== 2'b10 || ram_addr !== 32'h104) begin
            fails = fails + 1;
            $display("FAIL simul_if_next: got gnt=%b addr=%h, required 10 addr=00000104", {if_gnt, mem_gnt}, ram_addr);
        end
        push(1'b0, 32'h33334444);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        mem_req   = 1'b1;
        mem_wen   = 4'b0100;
        mem_addr  = 32'h302;
        mem_wdata = 32'h00AB0000;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({mem_gnt, ram_en, ram_wen} !== 6'b110100 || ram_wdata !== 32'h00AB0000 || ram_addr !== 32'h302) begin
            fails = fails + 1;
            $display("FAIL store_grant: got gnt/en/wen=%b wdata=%h addr=%h, required 110100 00ab0000 00000302",
                     {mem_gnt, ram_en, ram_wen}, ram_wdata, ram_addr);
        end
        @(posedge clk);
        #1;
        idle();
        mem_req  = 1'b1;
        mem_addr = 32'h300;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if (mem_rvalid !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL store_no_rvalid: got %b, required 0", mem_rvalid);
        end
        push(1'b1, 32'h12AB5678);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_starvation();
        mem_req  = 1'b1;
        mem_addr = 32'h200;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            tests = tests + 1;
            if ({if_gnt, mem_gnt} !== ((c == 4) ? 2'b10 : 2'b01)) begin
                fails = fails + 1;
                $display("FAIL starve_c%0d: got gnt=%b, required %b", c, {if_gnt, mem_gnt}, (c == 4) ? 2'b10 : 2'b01);
            end
            if (c == 4) push(1'b0, 32'hDEADBEEF);
            else push(1'b1, 32'h11112222);
            @(posedge clk);
            #1;
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({if_gnt, mem_gnt} !== 2'b10) begin
            fails = fails + 1;
            $display("FAIL b2b_if_grant: got %b, required 10", {if_gnt, mem_gnt});
        end
        push(1'b0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        idle();
        mem_req  = 1'b1;
        mem_addr = 32'h200;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({mem_gnt, if_rvalid, mem_rvalid} !== 3'b110 || if_rdata !== 32'hDEADBEEF) begin
            fails = fails + 1;
            $display("FAIL b2b_cycle1: got gnt/ifv/memv=%b data=%h, required 110 deadbeef",
                     {mem_gnt, if_rvalid, mem_rvalid}, if_rdata);
        end
        push(1'b1, 32'h11112222);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        #1;
        tests = tests + 1;
        if ({if_rvalid, mem_rvalid} !== 2'b01 || mem_rdata !== 32'h11112222) begin
            fails = fails + 1;
            $display("FAIL b2b_cycle2: got ifv/memv=%b data=%h, required 01 11112222", {if_rvalid, mem_rvalid}, mem_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_read();
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        #1;
        tests = tests + 1;
        if (if_gnt !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL midrst_grant: got %b, required 1", if_gnt);
        end
        #1;
        resetn = 1'b0;
        #1;
        tests = tests + 1;
        if ({if_gnt, ram_en, if_rvalid} !== 3'b000) begin
            fails = fails + 1;
            $display("FAIL midrst_in_reset: got gnt/en/rvalid=%b, required 000", {if_gnt, ram_en, if_rvalid});
        end
        @(posedge clk);
        #1;
        tests = tests + 1;
        if (if_rvalid !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL midrst_edge: got if_rvalid=%b, required 0", if_rvalid);
        end
        idle();
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            tests = tests + 1;
            if (if_rvalid !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL midrst_after_%0d: got if_rvalid=%b, required 0", c, if_rvalid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[8'h40] = 32'hDEADBEEF;
        ram[8'h41] = 32'h33334444;
        ram[8'h80] = 32'h11112222;
        ram[8'hC0] = 32'h12345678;
        test_reset();
        test_sole_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        @(posedge clk);
        #1;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL missing_responses: got %0d outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
